// File: rtl/ct_ciu_snb_age_sched_pkg.sv
// rtl/ct_ciu_snb_age_sched_pkg.sv - shared CIU snoop-buffer scheduler configuration
package ct_ciu_snb_age_sched_pkg;

    localparam int SAB_DEPTH = 24;

    typedef enum logic {
        SCHED_IDLE  = 1'b0,
        SCHED_GRANT = 1'b1
    } sched_state_e;

endpackage

// File: rtl/ct_ciu_snb_age_sched_if.sv
// rtl/ct_ciu_snb_age_sched_if.sv - allocation/request/issue bundle of the snoop-buffer age scheduler
interface ct_ciu_snb_age_sched_if
    import ct_ciu_snb_age_sched_pkg::*;
#(
    parameter int DEPTH = SAB_DEPTH
) ();

    logic             alloc_vld;
    logic [DEPTH-1:0] alloc_ptr;
    logic [DEPTH-1:0] dealloc_vect;
    logic [DEPTH-1:0] req_vld;
    logic             issue_vld;
    logic [DEPTH-1:0] issue_ptr;
    logic             issue_rdy;
    logic [DEPTH-1:0] entry_vld;

    modport master (
        output alloc_vld, alloc_ptr, dealloc_vect, req_vld, issue_rdy,
        input  issue_vld, issue_ptr, entry_vld
    );

    modport slave (
        input  alloc_vld, alloc_ptr, dealloc_vect, req_vld, issue_rdy,
        output issue_vld, issue_ptr, entry_vld
    );

endinterface

// File: rtl/ct_ciu_snb_age_oldest.sv
// rtl/ct_ciu_snb_age_oldest.sv - picks the candidate with no older candidate in its age row
module ct_ciu_snb_age_oldest
    import ct_ciu_snb_age_sched_pkg::*;
#(
    parameter int DEPTH = SAB_DEPTH
) (
    input  logic [DEPTH-1:0]            candidates,
    input  logic [DEPTH-1:0][DEPTH-1:0] age_rows,
    output logic [DEPTH-1:0]            oldest_sel
);

    // Valid entries form a total order, so exactly one candidate survives.
    for (genvar i = 0; i < DEPTH; i++) begin : g_sel
        assign oldest_sel[i] = candidates[i] & ~(|(age_rows[i] & candidates));
    end

endmodule

// File: rtl/ct_ciu_snb_age_sched.sv
// rtl/ct_ciu_snb_age_sched.sv - age-ordered issue scheduler for the CIU snoop buffer
module ct_ciu_snb_age_sched
    import ct_ciu_snb_age_sched_pkg::*;
#(
    parameter int DEPTH = SAB_DEPTH
) (
    input logic                   forever_cpuclk,
    input logic                   cpurst_b,
    ct_ciu_snb_age_sched_if.slave bus
);

    logic [DEPTH-1:0]            entry_vld_q, entry_vld_d;
    logic [DEPTH-1:0]            issued_q, issued_d;
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
    sched_state_e                state_q;
    logic                        issue_vld_q;
    logic [DEPTH-1:0]            issue_ptr_q;

    logic             handshake;
    logic             cancel;
    logic             alloc_ok;
    logic [DEPTH-1:0] keep_vld;
    logic [DEPTH-1:0] candidates;
    logic [DEPTH-1:0] oldest_sel;
    logic             any_cand;

    assign handshake = issue_vld_q & bus.issue_rdy;
    assign cancel    = issue_vld_q & (|(issue_ptr_q & bus.dealloc_vect));
    assign keep_vld  = entry_vld_q & ~bus.dealloc_vect;
    assign alloc_ok  = bus.alloc_vld & ~(|(bus.alloc_ptr & keep_vld));

    // issue_ptr_q is zero outside GRANT, so masking it removes only the pending grant.
    assign candidates = bus.req_vld & keep_vld & ~issued_q & ~issue_ptr_q;
    assign any_cand   = |candidates;

    ct_ciu_snb_age_oldest #(
        .DEPTH (DEPTH)
    ) u_oldest (
        .candidates (candidates),
        .age_rows   (age_q),
        .oldest_sel (oldest_sel)
    );

    always_comb begin
        entry_vld_d = keep_vld;
        issued_d    = (issued_q | ({DEPTH{handshake}} & issue_ptr_q)) & ~bus.dealloc_vect;
        age_d       = age_q;
        if (alloc_ok) begin
            entry_vld_d = entry_vld_d | bus.alloc_ptr;
            issued_d    = issued_d & ~bus.alloc_ptr;
            for (int r = 0; r < DEPTH; r++) begin
                if (bus.alloc_ptr[r]) begin
                    age_d[r] = keep_vld & ~bus.alloc_ptr;
                end else begin
                    age_d[r] = age_q[r] & ~bus.alloc_ptr;
                end
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            entry_vld_q <= '0;
            issued_q    <= '0;
            age_q       <= '0;
        end else begin
            entry_vld_q <= entry_vld_d;
            issued_q    <= issued_d;
            age_q       <= age_d;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= SCHED_IDLE;
            issue_vld_q <= 1'b0;
            issue_ptr_q <= '0;
        end else begin
            case (state_q)
                SCHED_IDLE: begin
                    if (any_cand) begin
                        state_q     <= SCHED_GRANT;
                        issue_vld_q <= 1'b1;
                        issue_ptr_q <= oldest_sel;
                    end
                end
                SCHED_GRANT: begin
                    if (cancel || (handshake && !any_cand)) begin
                        state_q     <= SCHED_IDLE;
                        issue_vld_q <= 1'b0;
                        issue_ptr_q <= '0;
                    end else if (handshake) begin
                        issue_ptr_q <= oldest_sel;
                    end
                end
                default: begin
                    state_q     <= SCHED_IDLE;
                    issue_vld_q <= 1'b0;
                    issue_ptr_q <= '0;
                end
            endcase
        end
    end

    assign bus.issue_vld = issue_vld_q;
    assign bus.issue_ptr = issue_ptr_q;
    assign bus.entry_vld = entry_vld_q;

    logic age_antisym;
    always_comb begin
        age_antisym = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((i != j) && entry_vld_q[i] && entry_vld_q[j] && (age_q[i][j] == age_q[j][i])) begin
                    age_antisym = 1'b0;
                end
            end
        end
    end

    a_alloc_onehot: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
        bus.alloc_vld |-> $onehot(bus.alloc_ptr));

    a_alloc_free: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
        bus.alloc_vld |-> !(|(bus.alloc_ptr & keep_vld)));

    a_issue_onehot0: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
        $onehot0(issue_ptr_q) && (issue_vld_q || (issue_ptr_q == '0)));

    a_age_antisym: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
        age_antisym);

endmodule

// File: tb/tb_ct_ciu_snb_age_sched.sv
// tb/tb_ct_ciu_snb_age_sched.sv - directed and randomized checks of the snoop-buffer age scheduler
module tb_ct_ciu_snb_age_sched;
    import ct_ciu_snb_age_sched_pkg::*;

    localparam int D = SAB_DEPTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    ct_ciu_snb_age_sched_if #(.DEPTH(D)) bus ();

    ct_ciu_snb_age_sched #(.DEPTH(D)) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Reference model: each entry carries an allocation sequence number; oldest = smallest.
    logic [D-1:0] m_vld;
    logic [D-1:0] m_iss;
    int           m_stamp [D];
    int           m_seq;
    logic         m_ivld;
    int           m_iptr;

    function automatic logic [31:0] bit_of(input int idx);
        logic [31:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_vld  = '0;
        m_iss  = '0;
        m_seq  = 0;
        m_ivld = 1'b0;
        m_iptr = -1;
        for (int i = 0; i < D; i++) m_stamp[i] = 0;
    endtask

    task automatic model_step(input logic av, input int ai, input logic [D-1:0] dv,
                              input logic [D-1:0] rv, input logic rdy);
        logic hs, cancel, n_ivld;
        int   best, n_iptr;
        hs     = m_ivld && rdy;
        cancel = m_ivld && dv[m_iptr];
        best   = -1;
        for (int i = 0; i < D; i++) begin
            if (rv[i] && m_vld[i] && !m_iss[i] && !dv[i] && !(m_ivld && i == m_iptr)) begin
                if (best < 0 || m_stamp[i] < m_stamp[best]) best = i;
            end
        end
        n_ivld = m_ivld;
        n_iptr = m_iptr;
        if (!m_ivld || (hs && !cancel)) begin
            n_ivld = (best >= 0);
            n_iptr = best;
        end else if (cancel) begin
            n_ivld = 1'b0;
        end
        if (hs) m_iss[m_iptr] = 1'b1;
        for (int i = 0; i < D; i++) begin
            if (dv[i]) begin
                m_vld[i] = 1'b0;
                m_iss[i] = 1'b0;
            end
        end
        if (av && !m_vld[ai]) begin
            m_vld[ai]   = 1'b1;
            m_iss[ai]   = 1'b0;
            m_stamp[ai] = m_seq;
            m_seq++;
        end
        m_ivld = n_ivld;
        m_iptr = n_ivld ? n_iptr : -1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic av, input int ai, input logic [D-1:0] dv,
                        input logic [D-1:0] rv, input logic rdy);
        logic [D-1:0] ap;
        ap = '0;
        if (av) ap[ai] = 1'b1;
        bus.alloc_vld    = av;
        bus.alloc_ptr    = ap;
        bus.dealloc_vect = dv;
        bus.req_vld      = rv;
        bus.issue_rdy    = rdy;
        model_step(av, ai, dv, rv, rdy);
        @(posedge clk);
        #1;
        chk("model_issue_vld", 32'(bus.issue_vld), 32'(m_ivld));
        chk("model_issue_ptr", 32'(bus.issue_ptr), bit_of(m_iptr));
        chk("model_entry_vld", 32'(bus.entry_vld), 32'(m_vld));
    endtask

    task automatic clear_all();
        step(1'b0, 0, {D{1'b1}}, '0, 1'b1);
    endtask

    initial begin
        logic [D-1:0] all_ones;
        logic [D-1:0] dv, rv;
        logic [31:0]  r;
        logic         av;
        int           ai;
        all_ones = {D{1'b1}};

        bus.alloc_vld    = 1'b0;
        bus.alloc_ptr    = '0;
        bus.dealloc_vect = '0;
        bus.req_vld      = '0;
        bus.issue_rdy    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_issue_vld", 32'(bus.issue_vld), 32'd0);
        chk("reset_issue_ptr", 32'(bus.issue_ptr), 32'd0);
        chk("reset_entry_vld", 32'(bus.entry_vld), 32'd0);
        rst_n = 1'b1;

        // Ordering: allocation order 5, 2, 9 is the grant order.
        step(1'b1, 5, '0, '0, 1'b0);
        step(1'b1, 2, '0, '0, 1'b0);
        step(1'b1, 9, '0, '0, 1'b0);
        rv = '0; rv[5] = 1'b1; rv[2] = 1'b1; rv[9] = 1'b1;
        step(1'b0, 0, '0, rv, 1'b1);
        chk("order_first", 32'(bus.issue_ptr), 32'h20);
        step(1'b0, 0, '0, rv, 1'b1);
        chk("order_second", 32'(bus.issue_ptr), 32'h4);
        step(1'b0, 0, '0, rv, 1'b1);
        chk("order_third", 32'(bus.issue_ptr), 32'h200);
        step(1'b0, 0, '0, rv, 1'b1);
        chk("order_drain", 32'(bus.issue_vld), 32'd0);
        clear_all();

        // Backpressure holds the grant stable.
        step(1'b1, 3, '0, '0, 1'b0);
        step(1'b1, 4, '0, '0, 1'b0);
        rv = '0; rv[3] = 1'b1; rv[4] = 1'b1;
        step(1'b0, 0, '0, rv, 1'b0);
        chk("bp_grant", 32'(bus.issue_ptr), 32'h8);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 0, '0, rv, 1'b0);
            chk("bp_hold", 32'(bus.issue_ptr), 32'h8);
        end
        step(1'b0, 0, '0, rv, 1'b1);
        chk("bp_next", 32'(bus.issue_ptr), 32'h10);
        step(1'b0, 0, '0, rv, 1'b1);
        chk("bp_drain", 32'(bus.issue_vld), 32'd0);
        clear_all();

        // Cancel of the pending grant.
        step(1'b1, 3, '0, '0, 1'b0);
        step(1'b1, 6, '0, '0, 1'b0);
        rv = '0; rv[3] = 1'b1; rv[6] = 1'b1;
        step(1'b0, 0, '0, rv, 1'b0);
        chk("cancel_grant", 32'(bus.issue_ptr), 32'h8);
        dv = '0; dv[3] = 1'b1;
        step(1'b0, 0, dv, rv, 1'b0);
        chk("cancel_drop", 32'(bus.issue_vld), 32'd0);
        rv = '0; rv[6] = 1'b1;
        step(1'b0, 0, '0, rv, 1'b0);
        chk("cancel_regrant", 32'(bus.issue_ptr), 32'h40);
        clear_all();

        // Same-cycle reuse of entry 0 makes it younger than entry 7.
        step(1'b1, 0, '0, '0, 1'b0);
        step(1'b1, 7, '0, '0, 1'b0);
        dv = '0; dv[0] = 1'b1;
        step(1'b1, 0, dv, '0, 1'b0);
        chk("reuse_valid", 32'(bus.entry_vld), 32'h81);
        rv = '0; rv[0] = 1'b1; rv[7] = 1'b1;
        step(1'b0, 0, '0, rv, 1'b1);
        chk("reuse_first", 32'(bus.issue_ptr), 32'h80);
        step(1'b0, 0, '0, rv, 1'b1);
        chk("reuse_second", 32'(bus.issue_ptr), 32'h1);
        clear_all();

        // Fill, recycle entry 0, drain in age order.
        for (int i = 0; i < D; i++) step(1'b1, i, '0, '0, 1'b0);
        chk("full_valid", 32'(bus.entry_vld), 32'(all_ones));
        dv = '0; dv[0] = 1'b1;
        step(1'b1, 0, dv, '0, 1'b0);
        for (int k = 0; k < D; k++) begin
            step(1'b0, 0, '0, all_ones, 1'b1);
            chk("wrap_order", 32'(bus.issue_ptr), (k < D - 1) ? (32'd1 << (k + 1)) : 32'd1);
        end
        clear_all();

        for (int c = 0; c < 1500; c++) begin
            dv = '0;
            for (int i = 0; i < D; i++) begin
                if (m_vld[i] && $urandom_range(0, 11) == 0) dv[i] = 1'b1;
            end
            if (m_ivld && $urandom_range(0, 7) == 0) dv[m_iptr] = 1'b1;
            av = 1'($urandom_range(0, 1));
            ai = $urandom_range(0, D - 1);
            if (m_vld[ai] && !dv[ai]) av = 1'b0;
            r  = $urandom();
            rv = r[D-1:0];
            step(av, ai, dv, rv, ($urandom_range(0, 3) != 0));
        end
        clear_all();

        // Asynchronous reset while a grant is pending.
        step(1'b1, 10, '0, '0, 1'b0);
        rv = '0; rv[10] = 1'b1;
        step(1'b0, 0, '0, rv, 1'b0);
        chk("pre_reset_grant", 32'(bus.issue_ptr), 32'h400);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_issue_vld", 32'(bus.issue_vld), 32'd0);
        chk("async_rst_entry_vld", 32'(bus.entry_vld), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 0, '0, all_ones, 1'b1);
        chk("post_rst_idle", 32'(bus.issue_vld), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ct_ciu_snb_age_sched.md
CT_CIU_SNB_AGE_SCHED -- requirements
Module: ct_ciu_snb_age_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 24 (`SAB_DEPTH): number of snoop-buffer entries tracked; valid range 2..32.
REQ-002 SHALL have port forever_cpuclk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port cpurst_b, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port alloc_vld, input, 1: allocate one entry this cycle.
REQ-005 SHALL have port alloc_ptr, input, DEPTH: one-hot index of the entry being allocated.
REQ-006 SHALL have port dealloc_vect, input, DEPTH: entries freed this cycle (any number).
REQ-007 SHALL have port req_vld, input, DEPTH: entries currently ready to issue.
REQ-008 SHALL have port issue_vld, output, 1: registered grant valid.
REQ-009 SHALL have port issue_ptr, output, DEPTH: registered one-hot granted entry; all-zero when issue_vld=0.
REQ-010 SHALL have port issue_rdy, input, 1: consumer accepts the grant.
REQ-011 SHALL have port entry_vld, output, DEPTH: current occupancy vector.

Function
REQ-012 SHALL hold a DEPTH x DEPTH age matrix; row i bit j = 1 means entry j is older than entry i.
REQ-013 SHALL, on alloc of entry i, load row i with entry_vld & ~dealloc_vect (excluding bit i), clear column i in all other rows, and set entry_vld[i].
REQ-014 SHALL clear entry_vld and the issued flag for every set bit of dealloc_vect.
REQ-015 SHALL, when alloc and dealloc hit the same entry in one cycle, apply the dealloc to the old occupant and the alloc to the new one: entry ends valid, un-issued, with a fresh age row.
REQ-016 SHALL, when alloc_vld targets an already-valid entry not being deallocated, ignore the alloc; this is a protocol error flagged by an assertion.
REQ-017 SHALL form candidates = req_vld & entry_vld & ~issued & ~dealloc_vect & ~(pending grant), and select the single candidate whose age row ANDed with candidates is zero.
REQ-018 SHALL have a 1-cycle latency: candidates sampled in cycle t SHALL appear on issue_vld/issue_ptr in cycle t+1; an entry allocated in cycle t SHALL be eligible from cycle t+1.
REQ-019 SHALL hold issue_vld/issue_ptr stable while issue_vld=1 and issue_rdy=0, with no re-arbitration.
REQ-020 SHALL, on handshake (issue_vld & issue_rdy) in cycle t, set the granted entry's issued flag and register a new selection in the same edge, excluding the granted entry, so that back-to-back grants occur every cycle.
REQ-021 SHALL, when the pending granted entry is deallocated, drop issue_vld at the next edge and re-arbitrate from the remaining candidates.
REQ-022 SHALL drive issue_vld=0 when no candidate exists; req_vld for an invalid entry SHALL be ignored.
REQ-023 SHALL track the output FSM with two states. IDLE goes to GRANT when a candidate exists. GRANT goes to IDLE on handshake with no further candidate, or on dealloc of the granted entry. GRANT stays in GRANT otherwise.

Reset
REQ-024 SHALL asynchronously clear entry_vld, issued flags, the age matrix, issue_vld and issue_ptr to 0, with the FSM in IDLE.
REQ-025 SHALL, when reset is asserted mid-grant, drop issue_vld immediately; after release the block behaves as empty.

Structure
REQ-026 SHALL take DEPTH and the FSM state encoding from the shared CIU config/package (cpu_cfig.h).
REQ-027 SHALL place the combinational oldest-candidate selector in one sub-module, ct_ciu_snb_age_oldest, with inputs candidates and DEPTH age rows and output a one-hot select.
REQ-028 SHALL carry assertions for: one-hot alloc_ptr, one-hot-or-zero issue_ptr, and an antisymmetric age matrix over valid pairs.

Verification
REQ-029 SHALL cover ordering: alloc entries 5, 2, 9 on consecutive cycles, then req_vld set on all three -> grants 5, 2, 9 on three consecutive cycles with issue_rdy=1.
REQ-030 SHALL cover backpressure: grant of entry 3 with issue_rdy low for 4 cycles -> issue_ptr=0x8 held stable; rdy high -> next-oldest granted the following cycle.
REQ-031 SHALL cover cancel: dealloc entry 3 while it is the pending grant -> issue_vld=0 next cycle, then the remaining oldest candidate granted.
REQ-032 SHALL cover reuse: dealloc and alloc of entry 0 in the same cycle while entry 7 is valid -> entry 7 granted before entry 0.
REQ-033 SHALL cover full/wrap: fill all 24 entries, free and re-alloc entry 0 -> entry 0 is youngest, granted last; reset mid-stream -> entry_vld=0, issue_vld=0.
